// File: rtl/yutorina_insn_dec_pkg.sv
// rtl/yutorina_insn_dec_pkg.sv - Yutorina ISA opcodes, field codes and control encodings
package yutorina_insn_dec_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int GPR_ADDR_W  = 5;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [GPR_ADDR_W-1:0] GPR_LINK = 5'd31;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SHRL, ALU_SHLL
    } alu_op_e;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_R_W, MEM_R_H, MEM_R_HU, MEM_R_B, MEM_R_BU, MEM_W_W, MEM_W_H, MEM_W_B
    } mem_op_e;

    typedef enum logic [1:0] {
        CTRL_NONE, CTRL_LSR, CTRL_SSR, CTRL_EXRT
    } ctrl_op_e;

    typedef enum logic [2:0] {
        EXP_NONE, EXP_UNDEF_INSN, EXP_TRAP, EXP_PRIV_VIO
    } exp_code_e;

    localparam logic [5:0] OP_ANDR  = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h01;
    localparam logic [5:0] OP_ORR   = 6'h02;
    localparam logic [5:0] OP_ORI   = 6'h03;
    localparam logic [5:0] OP_XORR  = 6'h04;
    localparam logic [5:0] OP_XORI  = 6'h05;
    localparam logic [5:0] OP_ADDR  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h07;
    localparam logic [5:0] OP_SUBR  = 6'h08;
    localparam logic [5:0] OP_SHRLR = 6'h09;
    localparam logic [5:0] OP_SHRLI = 6'h0A;
    localparam logic [5:0] OP_SHLLR = 6'h0B;
    localparam logic [5:0] OP_SHLLI = 6'h0C;
    localparam logic [5:0] OP_LDW   = 6'h10;
    localparam logic [5:0] OP_LDH   = 6'h11;
    localparam logic [5:0] OP_LDHU  = 6'h12;
    localparam logic [5:0] OP_LDB   = 6'h13;
    localparam logic [5:0] OP_LDBU  = 6'h14;
    localparam logic [5:0] OP_STW   = 6'h18;
    localparam logic [5:0] OP_STH   = 6'h19;
    localparam logic [5:0] OP_STB   = 6'h1A;
    localparam logic [5:0] OP_BE    = 6'h20;
    localparam logic [5:0] OP_BNE   = 6'h21;
    localparam logic [5:0] OP_BUGT  = 6'h22;
    localparam logic [5:0] OP_BSGT  = 6'h23;
    localparam logic [5:0] OP_JR    = 6'h24;
    localparam logic [5:0] OP_CALL  = 6'h25;
    localparam logic [5:0] OP_TRAP  = 6'h30;
    localparam logic [5:0] OP_LSR   = 6'h31;
    localparam logic [5:0] OP_SSR   = 6'h32;
    localparam logic [5:0] OP_EXRT  = 6'h33;

endpackage

// File: rtl/yutorina_br_cmp.sv
// rtl/yutorina_br_cmp.sv - conditional branch comparator (BE/BNE/BUGT/BSGT)
module yutorina_br_cmp (
    input  logic [1:0]  cond_sel,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    output logic        cond
);

    // Select the condition from the low opcode bits of the branch group
    always_comb begin
        cond = 1'b0;
        case (cond_sel)
            2'd0: cond = (lhs == rhs);
            2'd1: cond = (lhs != rhs);
            2'd2: cond = (lhs > rhs);
            2'd3: cond = ($signed(lhs) > $signed(rhs));
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/yutorina_insn_dec.sv
// rtl/yutorina_insn_dec.sv - ID-stage instruction decoder; YUTORINA_DEC_STAT_EN adds an exception counter
module yutorina_insn_dec
    import yutorina_insn_dec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [31:0] if_insn,
    input  logic [29:0] if_pc,
    input  logic [31:0] gpr_r_data1,
    input  logic [31:0] gpr_r_data2,
    input  logic [31:0] spr_r_data,
    output logic [4:0]  gpr_r_addr1,
    output logic [4:0]  gpr_r_addr2,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic        gpr_we_,
    output logic [3:0]  mem_op,
    output logic [1:0]  ctrl_op,
    output logic [2:0]  exp_code,
    output logic        br_taken,
`ifdef YUTORINA_DEC_STAT_EN
    output logic [15:0] dec_exp_cnt,
`endif
    output logic [29:0] br_addr
);

    logic [5:0]  op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rc;
    logic [15:0] imm;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        br_cond;

    assign op   = if_insn[31:26];
    assign ra   = if_insn[25:21];
    assign rb   = if_insn[20:16];
    assign rc   = if_insn[15:11];
    assign imm  = if_insn[15:0];
    assign sext = {{16{imm[15]}}, imm};
    assign zext = {16'h0000, imm};

    assign gpr_r_addr1 = ra;
    assign gpr_r_addr2 = rb;

    yutorina_br_cmp u_br_cmp (
        .cond_sel (op[1:0]),
        .lhs      (gpr_r_data1),
        .rhs      (gpr_r_data2),
        .cond     (br_cond)
    );

    // Opcode decode into ALU, writeback, memory, control, branch and exception controls
    always_comb begin
        alu_op   = ALU_NOP;
        alu_lhs  = gpr_r_data1;
        alu_rhs  = gpr_r_data2;
        w_addr   = rc;
        w_data   = gpr_r_data2;
        gpr_we_  = DISABLE_;
        mem_op   = MEM_NONE;
        ctrl_op  = CTRL_NONE;
        exp_code = EXP_NONE;
        br_taken = 1'b0;
        br_addr  = if_pc + 30'd1 + sext[29:0];
        case (op)
            OP_ANDR:  begin alu_op = ALU_AND;  gpr_we_ = ENABLE_; end
            OP_ORR:   begin alu_op = ALU_OR;   gpr_we_ = ENABLE_; end
            OP_XORR:  begin alu_op = ALU_XOR;  gpr_we_ = ENABLE_; end
            OP_ADDR:  begin alu_op = ALU_ADD;  gpr_we_ = ENABLE_; end
            OP_SUBR:  begin alu_op = ALU_SUB;  gpr_we_ = ENABLE_; end
            OP_SHRLR: begin alu_op = ALU_SHRL; gpr_we_ = ENABLE_; end
            OP_SHLLR: begin alu_op = ALU_SHLL; gpr_we_ = ENABLE_; end
            OP_ANDI:  begin alu_op = ALU_AND;  alu_rhs = zext; w_addr = rb; gpr_we_ = ENABLE_; end
            OP_ORI:   begin alu_op = ALU_OR;   alu_rhs = zext; w_addr = rb; gpr_we_ = ENABLE_; end
            OP_XORI:  begin alu_op = ALU_XOR;  alu_rhs = zext; w_addr = rb; gpr_we_ = ENABLE_; end
            OP_ADDI:  begin alu_op = ALU_ADD;  alu_rhs = sext; w_addr = rb; gpr_we_ = ENABLE_; end
            OP_SHRLI: begin alu_op = ALU_SHRL; alu_rhs = zext; w_addr = rb; gpr_we_ = ENABLE_; end
            OP_SHLLI: begin alu_op = ALU_SHLL; alu_rhs = zext; w_addr = rb; gpr_we_ = ENABLE_; end
            OP_LDW, OP_LDH, OP_LDHU, OP_LDB, OP_LDBU: begin
                alu_op  = ALU_ADD;
                alu_rhs = sext;
                w_addr  = rb;
                gpr_we_ = ENABLE_;
                case (op)
                    OP_LDW:  mem_op = MEM_R_W;
                    OP_LDH:  mem_op = MEM_R_H;
                    OP_LDHU: mem_op = MEM_R_HU;
                    OP_LDB:  mem_op = MEM_R_B;
                    default: mem_op = MEM_R_BU;
                endcase
            end
            OP_STW, OP_STH, OP_STB: begin
                alu_op  = ALU_ADD;
                alu_rhs = sext;
                case (op)
                    OP_STW:  mem_op = MEM_W_W;
                    OP_STH:  mem_op = MEM_W_H;
                    default: mem_op = MEM_W_B;
                endcase
            end
            OP_BE, OP_BNE, OP_BUGT, OP_BSGT: br_taken = br_cond;
            OP_JR: begin
                br_taken = 1'b1;
                br_addr  = gpr_r_data1[31:2];
            end
            OP_CALL: begin
                br_taken = 1'b1;
                br_addr  = gpr_r_data1[31:2];
                alu_op   = ALU_ADD;
                alu_lhs  = {if_pc + 30'd1, 2'b00};
                alu_rhs  = 32'h0;
                w_addr   = GPR_LINK;
                gpr_we_  = ENABLE_;
            end
            OP_TRAP: exp_code = EXP_TRAP;
            // Privileged ops in user mode collapse to defaults plus a violation
            OP_LSR: begin
                if (mode) begin
                    exp_code = EXP_PRIV_VIO;
                end else begin
                    ctrl_op = CTRL_LSR;
                    alu_op  = ALU_ADD;
                    alu_lhs = spr_r_data;
                    alu_rhs = 32'h0;
                    gpr_we_ = ENABLE_;
                end
            end
            OP_SSR: begin
                if (mode) begin
                    exp_code = EXP_PRIV_VIO;
                end else begin
                    ctrl_op = CTRL_SSR;
                    alu_op  = ALU_ADD;
                    alu_lhs = gpr_r_data2;
                    alu_rhs = 32'h0;
                    w_addr  = ra;
                end
            end
            OP_EXRT: begin
                if (mode) begin
                    exp_code = EXP_PRIV_VIO;
                end else begin
                    ctrl_op = CTRL_EXRT;
                end
            end
            default: exp_code = EXP_UNDEF_INSN;
        endcase
    end

`ifdef YUTORINA_DEC_STAT_EN
    // Saturating count of cycles that decode an exception
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_exp_cnt <= 16'h0000;
        end else if ((exp_code != EXP_NONE) && (dec_exp_cnt != 16'hFFFF)) begin
            dec_exp_cnt <= dec_exp_cnt + 16'd1;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
`endif

endmodule

// File: tb/tb_yutorina_insn_dec.sv
// tb/tb_yutorina_insn_dec.sv - table-driven self-checking bench for yutorina_insn_dec
module tb_yutorina_insn_dec;
    import yutorina_insn_dec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] if_insn = 32'h0;
    logic [29:0] if_pc = 30'h0;
    logic [31:0] gpr_r_data1 = 32'h0;
    logic [31:0] gpr_r_data2 = 32'h0;
    logic [31:0] spr_r_data = 32'h0;
    logic [4:0]  gpr_r_addr1, gpr_r_addr2, w_addr;
    logic [2:0]  alu_op, exp_code;
    logic [31:0] alu_lhs, alu_rhs, w_data;
    logic        gpr_we_, br_taken;
    logic [3:0]  mem_op;
    logic [1:0]  ctrl_op;
    logic [29:0] br_addr;
`ifdef YUTORINA_DEC_STAT_EN
    logic [15:0] dec_exp_cnt;
`endif

    yutorina_insn_dec dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .if_insn     (if_insn),
        .if_pc       (if_pc),
        .gpr_r_data1 (gpr_r_data1),
        .gpr_r_data2 (gpr_r_data2),
        .spr_r_data  (spr_r_data),
        .gpr_r_addr1 (gpr_r_addr1),
        .gpr_r_addr2 (gpr_r_addr2),
        .alu_op      (alu_op),
        .alu_lhs     (alu_lhs),
        .alu_rhs     (alu_rhs),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .gpr_we_     (gpr_we_),
        .mem_op      (mem_op),
        .ctrl_op     (ctrl_op),
        .exp_code    (exp_code),
        .br_taken    (br_taken),
`ifdef YUTORINA_DEC_STAT_EN
        .dec_exp_cnt (dec_exp_cnt),
`endif
        .br_addr     (br_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] insn;
        logic [29:0] pc;
        logic [31:0] r1, r2, spr;
        logic [2:0]  alu;
        logic [31:0] lhs, rhs;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        we_;
        logic [3:0]  mem;
        logic [1:0]  ctrl;
        logic [2:0]  exp;
        logic        bt;
        logic [29:0] ba;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic add(input logic md, input logic [31:0] insn, input logic [29:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] spr,
                       input logic [2:0] alu, input logic [31:0] lhs, input logic [31:0] rhs,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we_,
                       input logic [3:0] mem, input logic [1:0] ctrl, input logic [2:0] exp,
                       input logic bt, input logic [29:0] ba);
        vec_t v;
        v.mode = md; v.insn = insn; v.pc = pc; v.r1 = r1; v.r2 = r2; v.spr = spr;
        v.alu = alu; v.lhs = lhs; v.rhs = rhs; v.wa = wa; v.wd = wd; v.we_ = we_;
        v.mem = mem; v.ctrl = ctrl; v.exp = exp; v.bt = bt; v.ba = ba;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t e;
        //   md  insn          pc         r1            r2         spr       alu lhs           rhs           wa     wd         we_  mem ctrl exp bt ba
        add(1'b0, 32'h1C22FFFF, 30'h0,     32'h5,        32'h0,     32'h0,    4, 32'h5,        32'hFFFFFFFF, 5'd2,  32'h0,     1'b0, 0, 0,  0,  0, 30'h0);
        add(1'b0, 32'h8422FFFE, 30'h100,   32'h3,        32'h4,     32'h0,    0, 32'h3,        32'h4,        5'd31, 32'h4,     1'b1, 0, 0,  0,  1, 30'hFF);
        add(1'b0, 32'h8422FFFE, 30'h100,   32'h4,        32'h4,     32'h0,    0, 32'h4,        32'h4,        5'd31, 32'h4,     1'b1, 0, 0,  0,  0, 30'hFF);
        add(1'b0, 32'h8C220000, 30'h20,    32'hFFFFFFFF, 32'h1,     32'h0,    0, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,     1'b1, 0, 0,  0,  0, 30'h21);
        add(1'b0, 32'h88220000, 30'h20,    32'hFFFFFFFF, 32'h1,     32'h0,    0, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,     1'b1, 0, 0,  0,  1, 30'h21);
        add(1'b0, 32'h94200000, 30'h10,    32'h400,      32'h0,     32'h0,    4, 32'h44,       32'h0,        5'd31, 32'h0,     1'b0, 0, 0,  0,  1, 30'h100);
        add(1'b1, 32'hC4001800, 30'h0,     32'h11,       32'h22,    32'hABCD, 0, 32'h11,       32'h22,       5'd3,  32'h22,    1'b1, 0, 0,  3,  0, 30'h1801);
        add(1'b0, 32'hC4001800, 30'h0,     32'h11,       32'h22,    32'hABCD, 4, 32'hABCD,     32'h0,        5'd3,  32'h22,    1'b0, 0, 1,  0,  0, 30'h1801);
        add(1'b0, 32'hFC000000, 30'h5,     32'h7,        32'h9,     32'h0,    0, 32'h7,        32'h9,        5'd0,  32'h9,     1'b1, 0, 0,  1,  0, 30'h6);
        add(1'b0, 32'h60220010, 30'h0,     32'h1000,     32'hDEAD,  32'h0,    4, 32'h1000,     32'h10,       5'd0,  32'hDEAD,  1'b1, 6, 0,  0,  0, 30'h11);
        add(1'b0, 32'h4C22FFF0, 30'h0,     32'h2000,     32'h0,     32'h0,    4, 32'h2000,     32'hFFFFFFF0, 5'd2,  32'h0,     1'b0, 4, 0,  0,  0, 30'h3FFFFFF1);
        add(1'b0, 32'h0C228001, 30'h0,     32'h1,        32'h0,     32'h0,    2, 32'h1,        32'h8001,     5'd2,  32'h0,     1'b0, 0, 0,  0,  0, 30'h3FFF8002);
        add(1'b0, 32'h20221800, 30'h0,     32'hA,        32'h3,     32'h0,    5, 32'hA,        32'h3,        5'd3,  32'h3,     1'b0, 0, 0,  0,  0, 30'h1801);
        add(1'b1, 32'hC0000000, 30'h0,     32'h0,        32'h0,     32'h0,    0, 32'h0,        32'h0,        5'd0,  32'h0,     1'b1, 0, 0,  2,  0, 30'h1);
        add(1'b0, 32'hC8620000, 30'h0,     32'h5,        32'h77,    32'h0,    4, 32'h77,       32'h0,        5'd3,  32'h77,    1'b1, 0, 2,  0,  0, 30'h1);
        add(1'b0, 32'h90200000, 30'h0,     32'h803,      32'h0,     32'h0,    0, 32'h803,      32'h0,        5'd0,  32'h0,     1'b1, 0, 0,  0,  1, 30'h200);
        add(1'b1, 32'hCC000000, 30'h0,     32'h0,        32'h0,     32'h0,    0, 32'h0,        32'h0,        5'd0,  32'h0,     1'b1, 0, 0,  3,  0, 30'h1);

        repeat (2) @(posedge clk);
`ifdef YUTORINA_DEC_STAT_EN
        #1 chk("reset_cnt", {16'h0, dec_exp_cnt}, 32'h0);
`endif
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            mode = vecs[i].mode; if_insn = vecs[i].insn; if_pc = vecs[i].pc;
            gpr_r_data1 = vecs[i].r1; gpr_r_data2 = vecs[i].r2; spr_r_data = vecs[i].spr;
            sb.push_back(vecs[i]);
            @(negedge clk);
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_ra", i), {27'h0, gpr_r_addr1}, {27'h0, e.insn[25:21]});
                chk($sformatf("v%0d_rb", i), {27'h0, gpr_r_addr2}, {27'h0, e.insn[20:16]});
                chk($sformatf("v%0d_alu_op", i), {29'h0, alu_op}, {29'h0, e.alu});
                chk($sformatf("v%0d_alu_lhs", i), alu_lhs, e.lhs);
                chk($sformatf("v%0d_alu_rhs", i), alu_rhs, e.rhs);
                chk($sformatf("v%0d_w_addr", i), {27'h0, w_addr}, {27'h0, e.wa});
                chk($sformatf("v%0d_w_data", i), w_data, e.wd);
                chk($sformatf("v%0d_gpr_we_", i), {31'h0, gpr_we_}, {31'h0, e.we_});
                chk($sformatf("v%0d_mem_op", i), {28'h0, mem_op}, {28'h0, e.mem});
                chk($sformatf("v%0d_ctrl_op", i), {30'h0, ctrl_op}, {30'h0, e.ctrl});
                chk($sformatf("v%0d_exp_code", i), {29'h0, exp_code}, {29'h0, e.exp});
                chk($sformatf("v%0d_br_taken", i), {31'h0, br_taken}, {31'h0, e.bt});
                chk($sformatf("v%0d_br_addr", i), {2'h0, br_addr}, {2'h0, e.ba});
            end
        end

`ifdef YUTORINA_DEC_STAT_EN
        @(posedge clk);
        #1;
        if_insn = 32'h00000000;
        mode = 1'b0;
        rst = 1'b0;
        #1 chk("cnt_async_clear", {16'h0, dec_exp_cnt}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        if_insn = 32'hFC000000;
        repeat (3) @(posedge clk);
        #1 if_insn = 32'h00000000;
        chk("cnt_three_undef", {16'h0, dec_exp_cnt}, 32'h3);
        repeat (2) @(posedge clk);
        #1 chk("cnt_hold", {16'h0, dec_exp_cnt}, 32'h3);
        rst = 1'b0;
        #1 chk("cnt_reset", {16'h0, dec_exp_cnt}, 32'h0);
        rst = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/yutorina_insn_dec.md
Name: yutorina_insn_dec

Overview:
Instruction decoder of the Yutorina CPU ID stage. It maps one 32-bit fetched instruction into ALU, GPR-write, memory, control, branch and exception controls. Outputs are combinational; the ID stage registers them. The ID stage forwards the GPR read data before it reaches this block.

Parameters:
none (all widths come from the shared headers: WordDataBus 32, WordAddrBus 30, GprAddrBus 5, AluOpBus 3, MemOpBus 4, CtrlOpBus 2, ExpBus 3)

Ports:
clk  in  1  clock, used only by the optional counter
rst  in  1  reset, asynchronous, active-low (RESET_EDGE / RESET_ENABLE)
mode  in  1  privilege mode: 0 kernel, 1 user
if_insn  in  32  instruction to decode
if_pc  in  30  word address of the instruction
gpr_r_data1  in  32  forwarded value of GPR ra
gpr_r_data2  in  32  forwarded value of GPR rb
spr_r_data  in  32  SPR read value (the ID stage addresses the SPR by ra when ctrl_op is LSR)
gpr_r_addr1  out  5  ra = if_insn[25:21]
gpr_r_addr2  out  5  rb = if_insn[20:16]
alu_op  out  3  NOP, AND, OR, XOR, ADD, SUB, SHRL, SHLL
alu_lhs  out  32  ALU operand A
alu_rhs  out  32  ALU operand B
w_addr  out  5  GPR destination
w_data  out  32  store data
gpr_we_  out  1  GPR write enable, active-low
mem_op  out  4  NONE, R_W, R_H, R_HU, R_B, R_BU, W_W, W_H, W_B
ctrl_op  out  2  NONE, LSR, SSR, EXRT
exp_code  out  3  NONE, UNDEF_INSN, TRAP, PRIV_VIO
br_taken  out  1  branch taken
br_addr  out  30  branch target word address

Behaviour:
- Fields: op=[31:26], ra, rb, rc=[15:11], imm=[15:0]. sext = sign-extend imm; zext = zero-extend imm.
- Defaults: alu NOP; lhs=r1; rhs=r2; w_addr=rc; w_data=r2; gpr_we_ disabled; mem NONE; ctrl NONE; exp NONE; br_taken 0; br_addr=if_pc+1+sext[29:0].
- ALU opcodes write rd with we_ enabled:
  - R-form (rd=rc, rhs=r2): 00 ANDR, 02 ORR, 04 XORR, 06 ADDR, 08 SUBR, 09 SHRLR, 0B SHLLR.
  - I-form (rd=rb): 01 ANDI, 03 ORI, 05 XORI (rhs=zext); 07 ADDI (rhs=sext); 0A SHRLI, 0C SHLLI (rhs=zext).
- Loads 10 LDW, 11 LDH, 12 LDHU, 13 LDB, 14 LDBU: ADD, lhs=r1, rhs=sext, w_addr=rb, we_ enabled, mem R_*.
- Stores 18 STW, 19 STH, 1A STB: ADD, lhs=r1, rhs=sext, w_data=r2, we_ disabled, mem W_*.
- Branches:
  - 20 BE: r1==r2. 21 BNE: r1!=r2. 22 BUGT: unsigned r1>r2. 23 BSGT: signed r1>r2. br_taken=condition.
  - 24 JR: br_taken=1, br_addr=r1[31:2].
  - 25 CALL: br_taken=1, br_addr=r1[31:2], ADD lhs={if_pc+1,2'b00}, rhs=0, w_addr=31, we_ enabled.
- Control:
  - 30 TRAP: exp TRAP.
  - 31 LSR: ctrl LSR, ADD lhs=spr_r_data, rhs=0, w_addr=rc, we_ enabled.
  - 32 SSR: ctrl SSR, ADD lhs=r2, rhs=0, w_addr=ra (SPR index), we_ disabled.
  - 33 EXRT: ctrl EXRT.
  - LSR, SSR and EXRT are privileged. When mode=1 they produce exp PRIV_VIO, ctrl NONE, we_ disabled, br_taken 0.
- Any other opcode: all defaults, exp UNDEF_INSN.
- No internal state in the datapath; outputs settle within the same cycle. Reset affects only the optional counter.

Optional Feature:
YUTORINA_DEC_STAT_EN
- With it: adds output dec_exp_cnt (16 bits). The counter increments on posedge clk when exp_code!=NONE and saturates at 16'hFFFF. Asynchronous reset clears it to 0.
- Without it: port and counter absent; clk and rst are unused.

Decomposition:
- Shared headers isa.h, exp.h, gpr.h, spr.h hold the opcodes, field positions, ALU/MEM/CTRL/EXP codes, GPR_ZERO, bus widths, ENABLE_/DISABLE_ and RESET_ENABLE.
- A sub-module yutorina_br_cmp (comparator that yields the branch condition) is natural; all else stays inline.

Test Plan:
- ADDI r2<-r1+(-1): insn 0x1C22FFFF, r1=5 -> ADD, lhs=5, rhs=0xFFFFFFFF, w_addr=2, gpr_we_=0.
- BNE taken: op 21, r1=3, r2=4, if_pc=0x100, imm=0xFFFE -> br_taken=1, br_addr=0x0FF; with r1=r2 -> br_taken=0.
- BSGT vs BUGT: r1=0xFFFFFFFF, r2=1 -> BSGT not taken, BUGT taken.
- CALL: r1=0x400, if_pc=0x10 -> br_addr=0x100, lhs=0x44, w_addr=31, gpr_we_=0.
- LSR in user mode (mode=1) -> exp PRIV_VIO, gpr_we_=1, ctrl NONE; in kernel mode -> ctrl LSR, lhs=spr_r_data.
- Opcode 0x3F -> exp UNDEF_INSN, alu NOP, mem NONE. With YUTORINA_DEC_STAT_EN, three such cycles -> dec_exp_cnt=3; rst low -> 0.
